// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned RD_MAX_W  = 8;
   localparam int unsigned MUL_CNT_W = 4;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // Shadow copy of one pipeline register's destination info
   typedef struct packed {
      logic                valid;
      logic                wr_en;
      logic [RD_MAX_W-1:0] rd;
      logic                is_load;
   } stage_entry_t;

   // True when the entry will write a nonzero register equal to addr
   function automatic logic entry_writes(input stage_entry_t e, input logic [RD_MAX_W-1:0] addr);
      return e.valid && e.wr_en && (e.rd != '0) && (e.rd == addr);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: operand bypass select for one EX operand; MEM wins over WB.
module hazard_fwd_sel
   import hazard_pkg::*;
(
   input  stage_entry_t        mem_e,
   input  stage_entry_t        wb_e,
   input  logic [RD_MAX_W-1:0] op_addr,
   input  logic                op_used,
   output fwd_sel_t            sel_c
);

   // Youngest matching producer supplies the operand
   always_comb begin
      sel_c = FWD_RF;
      if (op_used && entry_writes(mem_e, op_addr)) begin
         sel_c = FWD_MEM;
      end else if (op_used && entry_writes(wb_e, op_addr)) begin
         sel_c = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, branch flush and multi-cycle
// multiply interlock for a 5-stage pipeline.
// Optional multiply interlock is enabled by defining HAZARD_MUL_EN.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned MUL_LAT    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  id_wr_en,
   input  logic                  id_is_load,
   input  logic                  id_is_mul,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  ex_branch_taken,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_write,
   output logic                  idex_bubble,
   output logic                  exmem_bubble,
   output logic                  ifid_flush,
   output logic                  mul_busy
);

   stage_entry_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   stage_entry_t          id_e;
   logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
   logic                  ex_uses_rs_q, ex_uses_rs_d, ex_uses_rt_q, ex_uses_rt_d;
   logic                  load_use_c;
   logic                  mul_busy_c;
   fwd_sel_t              fwd_a_sel, fwd_b_sel;

   assign id_e = '{valid: id_valid, wr_en: id_wr_en, rd: RD_MAX_W'(id_rd), is_load: id_is_load};

   // Load in EX whose result a used ID operand needs
   assign load_use_c = id_valid && ex_q.is_load &&
                       ((id_uses_rs && entry_writes(ex_q, RD_MAX_W'(id_rs))) ||
                        (id_uses_rt && entry_writes(ex_q, RD_MAX_W'(id_rt))));

`ifdef HAZARD_MUL_EN
   logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
   logic                 mul_start_c;

   assign mul_busy_c  = (mul_cnt_q != '0);
   assign mul_start_c = idex_write && !idex_bubble && id_valid && id_is_mul;

   // Remaining EX cycles of the multiply, excluding its final cycle
   always_comb begin
      mul_cnt_d = mul_cnt_q;
      if (mul_busy_c) begin
         mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
      end else if (mul_start_c) begin
         mul_cnt_d = MUL_CNT_W'(MUL_LAT - 1);
      end
   end

   // Multiply counter register; reset aborts an in-flight multiply
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mul_cnt_q <= '0;
      end else begin
         mul_cnt_q <= mul_cnt_d;
      end
   end
`else
   localparam int unsigned unused_mul_lat = MUL_LAT;
   logic unused_mul;

   assign mul_busy_c = 1'b0;
   assign unused_mul = id_is_mul;
`endif

   assign mul_busy = mul_busy_c;

   // Stage enables and bubbles: multiply > branch > load-use
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      ifid_flush   = 1'b0;
      if (mul_busy_c) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use_c) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   // Shadow pipeline advance; EX holds while the multiply is busy
   always_comb begin
      ex_d         = ex_q;
      ex_rs_d      = ex_rs_q;
      ex_rt_d      = ex_rt_q;
      ex_uses_rs_d = ex_uses_rs_q;
      ex_uses_rt_d = ex_uses_rt_q;
      if (idex_write) begin
         if (idex_bubble) begin
            ex_d         = '0;
            ex_uses_rs_d = 1'b0;
            ex_uses_rt_d = 1'b0;
         end else begin
            ex_d         = id_e;
            ex_rs_d      = id_rs;
            ex_rt_d      = id_rt;
            ex_uses_rs_d = id_uses_rs;
            ex_uses_rt_d = id_uses_rt;
         end
      end
      mem_d = exmem_bubble ? '0 : ex_q;
      wb_d  = mem_q;
   end

   // Shadow pipeline registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q         <= '0;
         mem_q        <= '0;
         wb_q         <= '0;
         ex_rs_q      <= '0;
         ex_rt_q      <= '0;
         ex_uses_rs_q <= 1'b0;
         ex_uses_rt_q <= 1'b0;
      end else begin
         ex_q         <= ex_d;
         mem_q        <= mem_d;
         wb_q         <= wb_d;
         ex_rs_q      <= ex_rs_d;
         ex_rt_q      <= ex_rt_d;
         ex_uses_rs_q <= ex_uses_rs_d;
         ex_uses_rt_q <= ex_uses_rt_d;
      end
   end

   hazard_fwd_sel u_fwd_a (
      .mem_e   (mem_q),
      .wb_e    (wb_q),
      .op_addr (RD_MAX_W'(ex_rs_q)),
      .op_used (ex_uses_rs_q),
      .sel_c   (fwd_a_sel)
   );

   hazard_fwd_sel u_fwd_b (
      .mem_e   (mem_q),
      .wb_e    (wb_q),
      .op_addr (RD_MAX_W'(ex_rt_q)),
      .op_used (ex_uses_rt_q),
      .sel_c   (fwd_b_sel)
   );

   assign fwd_a = fwd_a_sel;
   assign fwd_b = fwd_b_sel;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl (both HAZARD_MUL_EN builds).
module tb_hazard_ctrl;

   localparam int unsigned AW = 5;

   // ctrl = {0, pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush, mul_busy}
   localparam logic [7:0] CTRL_NORM  = 8'b0111_0000;
   localparam logic [7:0] CTRL_STALL = 8'b0001_1000;
   localparam logic [7:0] CTRL_BR    = 8'b0111_1010;
   localparam logic [7:0] CTRL_MUL   = 8'b0000_0101;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_is_mul;
   logic [AW-1:0] id_rs, id_rt, id_rd;
   logic          ex_branch_taken;
   logic [1:0]    fwd_a, fwd_b, fwd_a_1, fwd_b_1;
   logic          pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush, mul_busy;
   logic          pc_write_1, ifid_write_1, idex_write_1, idex_bubble_1, exmem_bubble_1, ifid_flush_1, mul_busy_1;
   logic [7:0]    ctrl, ctrl_1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign ctrl   = {1'b0, pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush, mul_busy};
   assign ctrl_1 = {1'b0, pc_write_1, ifid_write_1, idex_write_1, idex_bubble_1, exmem_bubble_1,
                    ifid_flush_1, mul_busy_1};

   hazard_ctrl #(.REG_ADDR_W(AW), .MUL_LAT(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken),
      .fwd_a(fwd_a), .fwd_b(fwd_b),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
      .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .ifid_flush(ifid_flush),
      .mul_busy(mul_busy)
   );

   hazard_ctrl #(.REG_ADDR_W(AW), .MUL_LAT(1)) u_dut_lat1 (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken),
      .fwd_a(fwd_a_1), .fwd_b(fwd_b_1),
      .pc_write(pc_write_1), .ifid_write(ifid_write_1), .idex_write(idex_write_1),
      .idex_bubble(idex_bubble_1), .exmem_bubble(exmem_bubble_1), .ifid_flush(ifid_flush_1),
      .mul_busy(mul_busy_1)
   );

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // f = {valid, uses_rs, uses_rt, wr_en, is_load, is_mul}
   task automatic set_id(input logic [5:0] f, input int rs, input int rt, input int rd);
      {id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_is_mul} = f;
      id_rs = AW'(rs);
      id_rt = AW'(rt);
      id_rd = AW'(rd);
   endtask

   task automatic idle();
      set_id(6'b000000, 0, 0, 0);
   endtask

   task automatic drain();
      idle();
      tick();
      tick();
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      ex_branch_taken = 1'b0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check_eq("rst_ctrl",  ctrl, CTRL_NORM);
      check_eq("rst_fwd_a", 8'(fwd_a), 8'd0);
      check_eq("rst_fwd_b", 8'(fwd_b), 8'd0);

      // ALU forwarding from MEM then WB
      set_id(6'b111100, 1, 2, 3); tick();
      set_id(6'b111100, 3, 4, 6); #1;
      check_eq("alu_no_stall", ctrl, CTRL_NORM); tick();
      set_id(6'b111100, 3, 7, 8); #1;
      check_eq("fwd_a_mem", 8'(fwd_a), 8'd2);
      check_eq("fwd_b_rf",  8'(fwd_b), 8'd0); tick();
      set_id(6'b111100, 6, 8, 9); #1;
      check_eq("fwd_a_wb", 8'(fwd_a), 8'd1); tick();
      set_id(6'b110100, 9, 0, 9); #1;
      check_eq("fwd_a_wb_r6",  8'(fwd_a), 8'd1);
      check_eq("fwd_b_mem_r8", 8'(fwd_b), 8'd2); tick();
      set_id(6'b110000, 9, 9, 0); #1;
      check_eq("fwd_a_mem_r9", 8'(fwd_a), 8'd2); tick();
      idle(); #1;
      check_eq("fwd_prio_mem", 8'(fwd_a), 8'd2);
      check_eq("fwd_b_unused", 8'(fwd_b), 8'd0);
      drain();

      // Load-use stall on rt
      set_id(6'b110110, 1, 0, 5); tick();
      set_id(6'b111100, 2, 5, 10); #1;
      check_eq("lu_stall", ctrl, CTRL_STALL); tick();
      #1;
      check_eq("lu_one_cycle", ctrl, CTRL_NORM); tick();
      idle(); #1;
      check_eq("lu_fwd_b_wb", 8'(fwd_b), 8'd1);
      check_eq("lu_fwd_a_rf", 8'(fwd_a), 8'd0);
      set_id(6'b110110, 1, 0, 5); tick();
      set_id(6'b110100, 4, 5, 12); #1;
      check_eq("lu_unused_op", ctrl, CTRL_NORM);
      drain();

      // Writes to r0 never forward or stall
      set_id(6'b111100, 1, 2, 0); tick();
      set_id(6'b111110, 1, 2, 0); tick();
      set_id(6'b111100, 0, 0, 13); #1;
      check_eq("r0_no_stall", ctrl, CTRL_NORM); tick();
      idle(); #1;
      check_eq("r0_fwd_a", 8'(fwd_a), 8'd0);
      check_eq("r0_fwd_b", 8'(fwd_b), 8'd0);
      drain();

      // Branch beats load-use; wrong-path ID instruction squashed
      set_id(6'b110110, 1, 0, 5); tick();
      set_id(6'b110100, 5, 0, 14);
      ex_branch_taken = 1'b1; #1;
      check_eq("br_over_lu", ctrl, CTRL_BR); tick();
      ex_branch_taken = 1'b0;
      set_id(6'b110000, 14, 0, 0); #1;
      check_eq("br_after", ctrl, CTRL_NORM); tick();
      idle(); #1;
      check_eq("br_squash", 8'(fwd_a), 8'd0);
      drain();

      // Multiply occupancy with forwarding on held operands
      set_id(6'b111100, 2, 3, 1); tick();
      set_id(6'b111101, 1, 2, 7); tick();
      set_id(6'b110100, 7, 0, 11); #1;
      check_eq("lat1_no_busy", ctrl_1, CTRL_NORM);
      check_eq("lat1_fwd", 8'(fwd_a_1), 8'd2);
      check_eq("mul_fwd_mem", 8'(fwd_a), 8'd2);
`ifdef HAZARD_MUL_EN
      check_eq("mul_busy_1", ctrl, CTRL_MUL); tick();
      ex_branch_taken = 1'b1; #1;
      check_eq("mul_busy_2_br", ctrl, CTRL_MUL);
      check_eq("mul_fwd_wb", 8'(fwd_a), 8'd1); tick();
      ex_branch_taken = 1'b0; #1;
      check_eq("mul_busy_3", ctrl, CTRL_MUL);
      check_eq("mul_fwd_rf", 8'(fwd_a), 8'd0); tick();
      #1;
      check_eq("mul_done", ctrl, CTRL_NORM); tick();
`else
      check_eq("mul_ignored", ctrl, CTRL_NORM); tick();
`endif
      idle(); #1;
      check_eq("mul_result_fwd", 8'(fwd_a), 8'd2);
      drain();

      // Reset in the middle of a multiply
      set_id(6'b111101, 1, 2, 7); tick();
      set_id(6'b110000, 7, 0, 0); tick();
      #1;
`ifdef HAZARD_MUL_EN
      check_eq("rst_pre_busy", ctrl, CTRL_MUL);
`else
      check_eq("rst_pre_fwd", 8'(fwd_a), 8'd2);
`endif
      rst_n = 1'b0;
      idle(); tick();
      rst_n = 1'b1; #1;
      check_eq("rst_mid_ctrl",  ctrl, CTRL_NORM);
      check_eq("rst_mid_fwd_a", 8'(fwd_a), 8'd0);
      check_eq("rst_mid_fwd_b", 8'(fwd_b), 8'd0);
      tick(); #1;
      check_eq("rst_no_resume", ctrl, CTRL_NORM);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
